// File: rtl/edf_prio_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : edf_prio_fifo_pkg
//  Description : Shared constants, order-list entry type and key-slice helper
//                for the earliest-deadline-first priority FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package edf_prio_fifo_pkg;

    localparam int EDF_ADDR_WIDTH  = 5;
    localparam int EDF_DATA_WIDTH  = 183;
    localparam int EDF_LABEL_WIDTH = 16;
    localparam int EDF_DEPTH       = 2 ** EDF_ADDR_WIDTH;

    // One order-list entry: sort key plus the payload slot it points at.
    typedef struct packed {
        logic [EDF_LABEL_WIDTH-1:0] key;
        logic [EDF_ADDR_WIDTH-1:0]  slot;
    } ord_entry_t;

    // Sort key is the MSB-aligned LABEL_WIDTH slice of the stored word.
    function automatic logic [EDF_LABEL_WIDTH-1:0] key_of(
        input logic [EDF_DATA_WIDTH-1:0] word
    );
        return word[EDF_DATA_WIDTH-1 -: EDF_LABEL_WIDTH];
    endfunction

endpackage
`default_nettype wire

// File: rtl/edf_prio_fifo_dpram_sclk.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_sclk
//  Description : Single-clock dual-port RAM, one write port and one read port
//                with a registered, enable-held read output.
//  Ports       : clk, rst          clock / synchronous active-high reset
//                we_i, waddr_i, wdata_i   write port
//                re_i, raddr_i            read request / address
//                rdata_o                  registered read data (held)
//  Revision    : 1.0 - initial release
// ============================================================================
module dpram_sclk
    import edf_prio_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = EDF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = EDF_DATA_WIDTH,
    parameter bit CLEAR_ON_INIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst && CLEAR_ON_INIT) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The read register only loads on a read, so it doubles as the hold
    // register that keeps the last popped word stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_INIT) begin
                rdata_q <= '0;
            end
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/edf_prio_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : edf_prio_fifo
//  Description : Earliest-deadline-first priority queue. Pops return the
//                stored word with the smallest key; equal keys leave in
//                arrival order. Pop latency is one cycle.
//  Ports       : clk, rst   clock / synchronous active-high reset
//                we, din    push request and word
//                re         pop request
//                dout       last popped word, held between pops
//                valid      one-cycle pulse when dout was updated
//                empty/full occupancy flags decoded from the stored count
//  Revision    : 1.0 - initial release
// ============================================================================
module edf_prio_fifo
    import edf_prio_fifo_pkg::*;
#(
    // Width parameters must match the package constants that size the
    // order-list entry type; CLEAR_ON_INIT may be overridden freely.
    parameter int ADDR_WIDTH    = EDF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = EDF_DATA_WIDTH,
    parameter int LABEL_WIDTH   = EDF_LABEL_WIDTH,
    parameter bit CLEAR_ON_INIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  empty,
    output logic                  full
);

    localparam int              DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH:0]  count_q, count_d;
    ord_entry_t           ord_q [DEPTH];
    ord_entry_t           ord_d [DEPTH];
    logic [DEPTH-1:0]     ordv_q, ordv_d;
    logic [DEPTH-1:0]     free_q, free_d;
    logic                 valid_q;

    logic                 w_push, w_pop;
    logic [ADDR_WIDTH-1:0] w_free_slot;
    logic [ADDR_WIDTH:0]  w_pos, w_ins;
    ord_entry_t           w_new;
    ord_entry_t           w_base [DEPTH];
    logic [DEPTH-1:0]     w_basev;

    assign empty  = (count_q == '0);
    assign full   = (count_q == C_DEPTH);
    assign w_push = we & ~full;
    assign w_pop  = re & ~empty;
    assign valid  = valid_q;

    // Lowest-index free slot.
    always_comb begin
        w_free_slot = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (free_q[i]) begin
                w_free_slot = ADDR_WIDTH'(i);
            end
        end
    end

    assign w_new.key  = key_of(din);
    assign w_new.slot = w_free_slot;

    // The list is sorted, so entries with key <= new key form a prefix;
    // counting them gives the insertion point behind all ties.
    always_comb begin
        w_pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ordv_q[i] && (ord_q[i].key <= w_new.key)) begin
                w_pos = w_pos + C_ONE;
            end
        end
        // A concurrent pop shifts everything down one place first.
        w_ins = (w_pop && (w_pos != '0)) ? (w_pos - C_ONE) : w_pos;
    end

    // List after the (optional) head removal.
    always_comb begin
        for (int i = 0; i < DEPTH-1; i++) begin
            w_base[i]  = w_pop ? ord_q[i+1]  : ord_q[i];
            w_basev[i] = w_pop ? ordv_q[i+1] : ordv_q[i];
        end
        w_base[DEPTH-1]  = w_pop ? '0   : ord_q[DEPTH-1];
        w_basev[DEPTH-1] = w_pop ? 1'b0 : ordv_q[DEPTH-1];
    end

    // Insert the new entry at w_ins and shift the tail up.
    always_comb begin
        if (w_push && (w_ins == '0)) begin
            ord_d[0]  = w_new;
            ordv_d[0] = 1'b1;
        end else begin
            ord_d[0]  = w_base[0];
            ordv_d[0] = w_basev[0];
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (w_push && (w_ins == (ADDR_WIDTH+1)'(i))) begin
                ord_d[i]  = w_new;
                ordv_d[i] = 1'b1;
            end else if (w_push && (w_ins < (ADDR_WIDTH+1)'(i))) begin
                ord_d[i]  = w_base[i-1];
                ordv_d[i] = w_basev[i-1];
            end else begin
                ord_d[i]  = w_base[i];
                ordv_d[i] = w_basev[i];
            end
        end
    end

    // Freed slot is only marked free at the edge, so it cannot be picked
    // for a push in the same cycle.
    always_comb begin
        free_d = free_q;
        if (w_push) begin
            free_d[w_free_slot] = 1'b0;
        end
        if (w_pop) begin
            free_d[ord_q[0].slot] = 1'b1;
        end
    end

    always_comb begin
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_ONE;
            2'b01:   count_d = count_q - C_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ordv_q  <= '0;
            free_q  <= '1;
            valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ord_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            ordv_q  <= ordv_d;
            free_q  <= free_d;
            valid_q <= w_pop;
            ord_q   <= ord_d;
        end
    end

    dpram_sclk #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .CLEAR_ON_INIT (CLEAR_ON_INIT)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (w_push),
        .waddr_i (w_free_slot),
        .wdata_i (din),
        .re_i    (w_pop),
        .raddr_i (ord_q[0].slot),
        .rdata_o (dout)
    );

endmodule
`default_nettype wire

// File: tb/tb_edf_prio_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edf_prio_fifo
//  Description : Self-checking bench for edf_prio_fifo against a sorted-queue
//                reference model; directed scenarios then random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_edf_prio_fifo;

    localparam int AW    = 5;
    localparam int DW    = 183;
    localparam int LW    = 16;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          re  = 1'b0;
    logic          we  = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          valid;
    logic          empty;
    logic          full;

    always #5 clk = ~clk;

    edf_prio_fifo #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .LABEL_WIDTH   (LW),
        .CLEAR_ON_INIT (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .re    (re),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .valid (valid),
        .empty (empty),
        .full  (full)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    string         phase    = "reset";

    // Reference: queue kept sorted by key, ties in arrival order.
    logic [DW-1:0] mq [$];
    logic [DW-1:0] m_dout  = '0;
    logic          m_valid = 1'b0;

    task automatic check_val(input string tag, input logic [DW-1:0] obs,
                             input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %h expected %h", phase, tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [LW-1:0] k);
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return {k, r[DW-LW-1:0]};
    endfunction

    function automatic logic [LW-1:0] key(input logic [DW-1:0] w);
        return w[DW-1 -: LW];
    endfunction

    task automatic model_step(input logic w, input logic r, input logic rs,
                              input logic [DW-1:0] d);
        bit do_pop;
        bit do_push;
        int pos;
        if (rs) begin
            mq.delete();
            m_valid = 1'b0;
            m_dout  = '0;
        end else begin
            do_pop  = r && (mq.size() > 0);
            do_push = w && (mq.size() < DEPTH);
            m_valid = do_pop;
            if (do_pop) m_dout = mq.pop_front();
            if (do_push) begin
                pos = 0;
                while (pos < mq.size() && key(mq[pos]) <= key(d)) pos++;
                mq.insert(pos, d);
            end
        end
    endtask

    task automatic cycle(input logic w, input logic r, input logic rs,
                         input logic [DW-1:0] d);
        we  = w;
        re  = r;
        rst = rs;
        din = d;
        @(posedge clk);
        model_step(w, r, rs, d);
        #1;
        check_val("valid", DW'(valid), DW'(m_valid));
        check_val("dout",  dout, m_dout);
        check_val("empty", DW'(empty), DW'(mq.size() == 0));
        check_val("full",  DW'(full),  DW'(mq.size() == DEPTH));
    endtask

    task automatic push(input logic [LW-1:0] k);
        cycle(1'b1, 1'b0, 1'b0, mk(k));
    endtask

    task automatic pop();
        cycle(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [DW-1:0] wa, wb, wc;

        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, 1'b1, '0);
        check_val("rst_dout", dout, '0);

        phase = "t1_order";
        push(16'h0030); push(16'h0010); push(16'h0020);
        pop(); check_val("k0", DW'(key(dout)), DW'(16'h0010));
        pop(); check_val("k1", DW'(key(dout)), DW'(16'h0020));
        pop(); check_val("k2", DW'(key(dout)), DW'(16'h0030));
        idle();

        phase = "t2_ties";
        wa = mk(16'h0005); wb = mk(16'h0005); wc = mk(16'h0005);
        cycle(1'b1, 1'b0, 1'b0, wa);
        cycle(1'b1, 1'b0, 1'b0, wb);
        cycle(1'b1, 1'b0, 1'b0, wc);
        pop(); check_val("A", dout, wa);
        pop(); check_val("B", dout, wb);
        pop(); check_val("C", dout, wc);

        phase = "t3_full";
        for (int i = 0; i < DEPTH; i++) push(LW'($urandom_range(0, 65535)));
        check_val("full32", DW'(full), DW'(1'b1));
        push(16'h0000);
        for (int i = 0; i < DEPTH + 1; i++) pop();
        check_val("last_novalid", DW'(valid), DW'(1'b0));

        phase = "t4_nobypass";
        push(16'h0100);
        cycle(1'b1, 1'b1, 1'b0, mk(16'h0001));
        check_val("old_head", DW'(key(dout)), DW'(16'h0100));
        pop();
        check_val("new_head", DW'(key(dout)), DW'(16'h0001));

        phase = "t5_full_we_re";
        for (int i = 0; i < DEPTH; i++) push(LW'($urandom_range(0, 15)));
        cycle(1'b1, 1'b1, 1'b0, mk(16'h0000));
        check_val("not_full", DW'(full), DW'(1'b0));
        for (int i = 0; i < DEPTH; i++) pop();
        phase = "t5_empty_we_re";
        cycle(1'b1, 1'b1, 1'b0, mk(16'h0042));
        check_val("no_valid", DW'(valid), DW'(1'b0));
        pop();

        phase = "t6_reset";
        for (int i = 0; i < 4; i++) push(LW'($urandom_range(0, 255)));
        pop();
        cycle(1'b0, 1'b1, 1'b1, '0);
        check_val("rst_dout", dout, '0);
        pop();
        idle();

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            int  bias;
            bias = (i / 250) % 3;
            cycle(($urandom_range(0, 3) < (bias == 0 ? 3 : (bias == 1 ? 1 : 2))),
                  ($urandom_range(0, 3) < (bias == 0 ? 1 : (bias == 1 ? 3 : 2))),
                  ($urandom_range(0, 299) == 0),
                  mk(LW'($urandom_range(0, 7))));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
